tmr_recovery_ctrl: RTL
======================

# tmr_recovery_ctrl

Sequential controller directly downstream of the TMR bus voter in the triple-lockstep cluster. It consumes the voter's `error_o`/`error_id_o` and classifies each detected divergence as recoverable (one hart disagrees) or fatal (two or more harts, or an unattributed error). For a recoverable divergence it halts all harts, raises a resynchronisation interrupt, waits for software to finish the resync, and releases the harts. It also keeps saturating per-hart error counters for the safety status registers.

## Interface
Parameters:
- `NHARTS`, 3: number of lockstep harts; must match the voter.
- `CNT_W`, 8: width of each per-hart error counter.
- `TIMEOUT`, 1024: cycles allowed in HALT for all acks; ≥2.

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `enable_i` in 1: TMR mode enable (same signal as the voter enable)
- `error_i` in 1: voter mismatch flag
- `error_id_i` in NHARTS: voter per-hart mismatch vector
- `halt_ack_i` in NHARTS: hart i is halted in debug mode
- `resync_done_i` in 1: software resync routine complete (level)
- `clear_i` in 1: clear counters and leave FATAL
- `halt_req_o` out NHARTS: halt request to each hart
- `faulty_id_o` out NHARTS: latched error_id of the current/last event
- `recovery_active_o` out 1: high in RESYNC
- `irq_o` out 1: one-cycle resync interrupt pulse
- `fatal_o` out 1: unrecoverable error, sticky
- `err_cnt_o` out NHARTS*CNT_W: counter of hart i in bits [i*CNT_W +: CNT_W]

## Operation
- States: IDLE, HALT, RESYNC, RELEASE, FATAL. Reset → IDLE.
- Event = `enable_i & error_i` sampled in IDLE. Events are ignored in all other states.
- Classification on event, using popcount of `error_id_i`:
  - ==1 → recoverable → HALT.
  - 0 or ≥2 → FATAL.
- On every event (either class):
  - `faulty_id_o <= error_id_i`.
  - Each counter i with `error_id_i[i]` increments by 1 and saturates at 2^CNT_W−1.
  - A multi-cycle `error_i` counts once, because the state leaves IDLE.
- HALT:
  - `halt_req_o` = all ones.
  - Timeout counter starts at 0 and increments each HALT cycle.
  - `&halt_ack_i` → RESYNC.
  - Otherwise, counter reaching TIMEOUT−1 → FATAL.
  - If all acks arrive in the same cycle the counter reaches TIMEOUT−1, the acks win (→ RESYNC).
- RESYNC:
  - `halt_req_o` stays all ones; `recovery_active_o` = 1.
  - `irq_o` = 1 in the first RESYNC cycle only.
  - `resync_done_i` → RELEASE.
- RELEASE: `halt_req_o` = 0 and `recovery_active_o` = 0 for exactly one cycle, then IDLE. No event is sampled in RELEASE.
- FATAL:
  - `fatal_o` = 1; `halt_req_o` = all ones, so all harts stay halted.
  - `clear_i` → IDLE and `fatal_o` cleared.
- `clear_i` in any state zeroes all counters next cycle. It changes state only in FATAL.
  - If `clear_i` and an event occur in the same IDLE cycle, the clear wins for the counters (result 0). The state transition and `faulty_id_o` latch still occur.
- `enable_i` deasserting outside IDLE has no effect; the sequence completes.
- `faulty_id_o` holds until the next event or reset.

## Timing
- All outputs registered. Reset value of every output is 0, and the state is IDLE.
- Event sampled at edge N:
  - `halt_req_o`, `faulty_id_o` and counters update at N+1.
  - Or `fatal_o` = 1 at N+1.
- All acks high in cycle M (in HALT): RESYNC from M+1; `irq_o` high during M+1 only.
- `resync_done_i` high in cycle K (in RESYNC): `halt_req_o`/`recovery_active_o` low from K+1; IDLE at K+2; earliest new event is sampled in cycle K+2.
- Timeout: with no acks, HALT lasts exactly TIMEOUT cycles, then FATAL.
- Asynchronous reset mid-sequence: all outputs drop to 0 immediately, counters cleared, state IDLE.

## Test plan
- Single-hart fault: `error_i`=1, `error_id_i`=3'b010 for 3 cycles; acks 3'b111 after 5 cycles; `resync_done_i` 10 cycles later.
  - Response: `halt_req_o`=3'b111 one cycle after the event; `faulty_id_o`=3'b010.
  - Hart 1 counter = 1 (not 3); one `irq_o` pulse; release one cycle after done; back in IDLE.
- Double-hart fault: `error_id_i`=3'b011 → `fatal_o`=1 next cycle, counters 0 and 1 = 1.
  - `clear_i` → `fatal_o`=0, all counters 0, IDLE.
- Unattributed error: `error_i`=1 with `error_id_i`=0 → FATAL, no counter changes.
- Halt timeout with TIMEOUT=16: acks 3'b101 only → FATAL after exactly 16 HALT cycles.
  - Repeat with all acks arriving on HALT cycle 16 → RESYNC, not FATAL.
- Saturation with CNT_W=2: five recoverable hart-0 events → counter 0 = 3.
  - `error_i` with `enable_i`=0 → no response.
  - Error asserted during RESYNC and RELEASE → ignored.
- Reset in RESYNC: assert `rst_ni`=0 → all outputs 0 without a clock edge. After release, a new event starts a fresh sequence.

Source files
------------

// File: rtl/tmr_recovery_ctrl_if.sv
// -----------------------------------------------------------------------------
// tmr_recovery_ctrl_if
//
// Signal bundle between the TMR recovery controller and its surroundings:
// the bus voter, the harts' debug halt interface, software and the safety
// status registers.
//
// Handshake: halt_req_o / halt_ack_i is a level-based request/acknowledge
// pair per hart. The controller raises halt_req_o[i] and holds it high.
// Hart i reports that it is halted by raising halt_ack_i[i] and keeping it
// high. Dropping halt_req_o releases the harts. resync_done_i is a level
// from software and is only looked at while the controller sits in RESYNC.
//
// Signals (directions as seen by the controller, modport master):
//   enable_i          in   TMR mode enable
//   error_i           in   voter mismatch flag
//   error_id_i        in   voter per-hart mismatch vector
//   halt_ack_i        in   hart i halted in debug mode
//   resync_done_i     in   software resync complete (level)
//   clear_i           in   clear counters, leave FATAL
//   halt_req_o        out  halt request per hart
//   faulty_id_o       out  latched error_id of the current/last event
//   recovery_active_o out  high while in RESYNC
//   irq_o             out  one-cycle resync interrupt
//   fatal_o           out  sticky unrecoverable-error flag
//   err_cnt_o         out  saturating error counter of hart i at [i*CNT_W +: CNT_W]
//   dbg_state         out  controller state:
//                          0 IDLE, 1 HALT, 2 RESYNC, 3 RELEASE, 4 FATAL
//
// Modports: master = controller side, slave = environment side.
// -----------------------------------------------------------------------------
interface tmr_recovery_ctrl_if #(
    parameter int NHARTS = 3,
    parameter int CNT_W  = 8
);
    logic                    enable_i;
    logic                    error_i;
    logic [NHARTS-1:0]       error_id_i;
    logic [NHARTS-1:0]       halt_ack_i;
    logic                    resync_done_i;
    logic                    clear_i;

    logic [NHARTS-1:0]       halt_req_o;
    logic [NHARTS-1:0]       faulty_id_o;
    logic                    recovery_active_o;
    logic                    irq_o;
    logic                    fatal_o;
    logic [NHARTS*CNT_W-1:0] err_cnt_o;
    logic [2:0]              dbg_state;

    modport master (
        input  enable_i,
        input  error_i,
        input  error_id_i,
        input  halt_ack_i,
        input  resync_done_i,
        input  clear_i,
        output halt_req_o,
        output faulty_id_o,
        output recovery_active_o,
        output irq_o,
        output fatal_o,
        output err_cnt_o,
        output dbg_state
    );

    modport slave (
        output enable_i,
        output error_i,
        output error_id_i,
        output halt_ack_i,
        output resync_done_i,
        output clear_i,
        input  halt_req_o,
        input  faulty_id_o,
        input  recovery_active_o,
        input  irq_o,
        input  fatal_o,
        input  err_cnt_o,
        input  dbg_state
    );
endinterface

// File: rtl/tmr_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_recovery_ctrl
//
// Sits behind the TMR bus voter and reacts to each divergence it reports.
// A divergence blamed on exactly one hart is recoverable: all harts are
// halted, software is interrupted to resynchronise the lagging hart, and
// the harts are released once software reports completion. Divergences
// blamed on zero or on two or more harts are fatal and park the cluster,
// all harts held in halt, until cleared. Per-hart saturating error
// counters feed the safety status registers.
//
// Parameters:
//   NHARTS   number of lockstep harts (must match the voter and the interface)
//   CNT_W    width of each per-hart error counter (must match the interface)
//   TIMEOUT  cycles allowed in HALT for all acknowledges, >= 2
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   bus      tmr_recovery_ctrl_if.master (see the interface for the signals)
//
// All outputs are registered and reset to 0; the state resets to IDLE.
// -----------------------------------------------------------------------------
module tmr_recovery_ctrl #(
    parameter int NHARTS  = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    tmr_recovery_ctrl_if.master    bus
);

    localparam int                 TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_RESYNC  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FATAL   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [NHARTS*CNT_W-1:0] cnt_q, cnt_d;
    logic [NHARTS-1:0]       fid_q, fid_d;
    logic [NHARTS-1:0]       halt_q, halt_d;
    logic                    active_q, active_d;
    logic                    irq_q, irq_d;
    logic                    fatal_q, fatal_d;
    logic                    evt;

    // True when exactly one hart is blamed, i.e. the divergence is recoverable.
    function automatic logic single_hart(input logic [NHARTS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NHARTS; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic. Events are only taken in IDLE, so an error held for
    // several cycles is seen once: the state has already moved on.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        evt     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable_i && bus.error_i) begin
                    evt     = 1'b1;
                    state_d = single_hart(bus.error_id_i) ? ST_HALT : ST_FATAL;
                end
            end

            ST_HALT: begin
                // Acks take priority over the timeout in the last HALT cycle.
                if (&bus.halt_ack_i) begin
                    state_d = ST_RESYNC;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_FATAL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_RESYNC: begin
                if (bus.resync_done_i) state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            ST_FATAL: begin
                if (bus.clear_i) state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output values are derived from the next state so that every output is
    // a flop yet changes in the same cycle as the state itself.
    // -------------------------------------------------------------------------
    always_comb begin
        halt_d   = '0;
        active_d = 1'b0;
        irq_d    = 1'b0;
        fatal_d  = 1'b0;

        unique case (state_d)
            ST_HALT: begin
                halt_d = '1;
            end
            ST_RESYNC: begin
                halt_d   = '1;
                active_d = 1'b1;
                irq_d    = (state_q != ST_RESYNC);
            end
            ST_FATAL: begin
                halt_d  = '1;
                fatal_d = 1'b1;
            end
            default: begin
                halt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Fault id latch and saturating per-hart counters. A clear in the same
    // cycle as an event wins for the counters; the id is still latched.
    // -------------------------------------------------------------------------
    always_comb begin
        fid_d = evt ? bus.error_id_i : fid_q;
        cnt_d = cnt_q;
        if (bus.clear_i) begin
            cnt_d = '0;
        end else if (evt) begin
            for (int i = 0; i < NHARTS; i++) begin
                if (bus.error_id_i[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            cnt_q    <= '0;
            fid_q    <= '0;
            halt_q   <= '0;
            active_q <= 1'b0;
            irq_q    <= 1'b0;
            fatal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            fid_q    <= fid_d;
            halt_q   <= halt_d;
            active_q <= active_d;
            irq_q    <= irq_d;
            fatal_q  <= fatal_d;
        end
    end

    assign bus.halt_req_o        = halt_q;
    assign bus.faulty_id_o       = fid_q;
    assign bus.recovery_active_o = active_q;
    assign bus.irq_o             = irq_q;
    assign bus.fatal_o           = fatal_q;
    assign bus.err_cnt_o         = cnt_q;
    assign bus.dbg_state         = state_q;

endmodule
